ras_ctrl: RTL and testbench
===========================

RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 Parameter STACKDEEP, 16, return-stack entries.
REQ-002 Parameter STACKPTRW, 4, stack pointer width.
REQ-003 Parameter STACKWIDE, 32, return-address width.
REQ-004 Parameter RECURCOUNT, 7, recursion-counter width; line width LW = STACKWIDE+RECURCOUNT.
REQ-005 Clk  in  1  single clock; all state updates on posedge.
REQ-006 Rest  in  1  reset, asynchronous, active-low.
REQ-007 PUSHREQ  in  1 / PUSHADDR  in  STACKWIDE / PUSHRDY  out  1  call-push handshake.
REQ-008 POPREQ  in  1 / POPRDY  out  1  return-pop handshake.
REQ-009 POPVALID  out  1 / POPADDR  out  STACKWIDE / POPMISS  out  1  pop result.
REQ-010 REDIRCT  in  1 / SNAPPTR  in  STACKPTRW  FTQ redirect and checkpointed pointer.
REQ-011 SNAPIDX  out  STACKPTRW / SNAPLINE  in  LW  snapshot line read port, combinational return.
REQ-012 STK_WABLE, STK_RABLE  out  1 / STK_DIN  out  STACKWIDE  stack push/pop strobes and data.
REQ-013 STK_DOUT  in  STACKWIDE / STK_FULL, STK_EMPTY  in  1  stack status.
REQ-014 STK_RSTWE  out  1 / STK_RSTIDX  out  STACKPTRW / STK_RSTLINE  out  LW  restore line write.
REQ-015 STK_RSTPTRWE  out  1 / STK_RSTPTR  out  STACKPTRW  restore pointer write.
REQ-016 RESTOREDONE  out  1  one-cycle pulse at restore end.

Function
REQ-017 FSM states IDLE, RESTORE, DONE; SHALL leave reset in IDLE.
REQ-018 IDLE: PUSHRDY = 1 unless POPREQ = 1; POPRDY = 1; in RESTORE/DONE both SHALL be 0.
REQ-019 Simultaneous PUSHREQ and POPREQ: pop granted, push held (PUSHRDY = 0) to next cycle.
REQ-020 Push grant with STK_FULL = 0: STK_WABLE = 1, STK_DIN = PUSHADDR, same cycle, combinational.
REQ-021 Push grant with STK_FULL = 1: accepted, not forwarded (STK_WABLE = 0), overflow event raised.
REQ-022 Pop grant with STK_EMPTY = 0: STK_RABLE = 1 same cycle; next cycle POPVALID = 1, POPADDR = STK_DOUT, POPMISS = 0.
REQ-023 Pop grant with STK_EMPTY = 1: STK_RABLE = 0; next cycle POPVALID = 1, POPMISS = 1, POPADDR = 0.
REQ-024 REDIRCT = 1 in any state: no grant that cycle, STK_WABLE/STK_RABLE = 0, pending POPVALID suppressed, capture SNAPPTR, index := 0, next state RESTORE.
REQ-025 RESTORE: each cycle SNAPIDX = index, STK_RSTWE = 1, STK_RSTIDX = index, STK_RSTLINE = SNAPLINE, index += 1; when index = captured pointer - 1 go DONE.
REQ-026 Captured SNAPPTR = 0: RESTORE skipped, next state DONE directly.
REQ-027 DONE (one cycle): STK_RSTPTRWE = 1, STK_RSTPTR = captured pointer, RESTOREDONE = 1; then IDLE.
REQ-028 REDIRCT during RESTORE or DONE restarts at index 0 with newly captured SNAPPTR; no DONE pulse for the aborted restore.
REQ-029 Index arithmetic SHALL be STACKPTRW-bit unsigned; SNAPPTR = STACKDEEP-1 restores entries 0..14 in 15 cycles.

Reset
REQ-030 Rest low SHALL asynchronously force state IDLE, index 0, captured pointer 0, POPVALID/POPMISS/POPADDR 0, RESTOREDONE 0, overflow counter 0.
REQ-031 All stack strobes (STK_WABLE, STK_RABLE, STK_RSTWE, STK_RSTPTRWE) SHALL be 0 while Rest low; reset mid-restore abandons it without DONE.

Configuration
REQ-032 Macro RAS_CTRL_OVFCNT_EN defined: output OVFCNT (8 bits) counts REQ-021 events, saturates at 255, clears on reset.
REQ-033 Macro undefined: OVFCNT port and counter absent; overflow pushes silently dropped.

Structure
REQ-034 Shared package ras_pkg SHALL hold FSM state typedef and default STACKDEEP/STACKPTRW/STACKWIDE/RECURCOUNT constants.
REQ-035 Restore index/pointer sequencing SHALL be sub-module ras_restore_seq; grant logic stays in ras_ctrl.

Verification
REQ-036 Push 0x1C000100 then pop, stack empty at start -> STK_WABLE cycle 0, POPVALID cycle after pop, POPADDR 0x1C000100, POPMISS 0.
REQ-037 Pop with STK_EMPTY = 1 -> STK_RABLE 0, next cycle POPVALID 1, POPMISS 1, POPADDR 0.
REQ-038 PUSHREQ and POPREQ same cycle -> POPRDY 1, PUSHRDY 0; push granted next cycle.
REQ-039 REDIRCT with SNAPPTR = 3 -> STK_RSTIDX 0,1,2 on three consecutive cycles, then STK_RSTPTR 3 with RESTOREDONE 1, IDLE next.
REQ-040 Push with STK_FULL = 1 three times (macro on) -> STK_WABLE 0, OVFCNT 3; second REDIRCT during restore restarts at index 0.

Source files
------------

// File: rtl/ras_pkg.sv
// Return-address-stack controller shared types and default sizes.
// Holds the controller FSM state type used by ras_ctrl and ras_restore_seq.
package ras_pkg;

    localparam int STACKDEEP_DEF  = 16;
    localparam int STACKPTRW_DEF  = 4;
    localparam int STACKWIDE_DEF  = 32;
    localparam int RECURCOUNT_DEF = 7;
    localparam int OVFCNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        RESTORE,
        DONE
    } ras_state_t;

endpackage

// File: rtl/ras_restore_seq.sv
// Checkpoint restore sequencer: walks snapshot lines 0..ptr-1 into the
// stack, then writes the restored pointer and pulses done for one cycle.
module ras_restore_seq
    import ras_pkg::*;
#(
    parameter int DEEP = STACKDEEP_DEF,
    parameter int PW   = STACKPTRW_DEF,
    parameter int LW   = STACKWIDE_DEF + RECURCOUNT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect,
    input  logic [PW-1:0] snap_ptr,
    input  logic [LW-1:0] snap_line,
    output logic [PW-1:0] snap_idx,
    output logic          rst_we,
    output logic [PW-1:0] rst_idx,
    output logic [LW-1:0] rst_line,
    output logic          rst_ptr_we,
    output logic [PW-1:0] rst_ptr,
    output logic          done,
    output logic          idle
);

    localparam logic [PW-1:0] MAX_PTR = PW'(DEEP - 1);

    ras_state_t    state, nxt_state;
    logic [PW-1:0] idx, nxt_idx;
    logic [PW-1:0] cap, nxt_cap;
    logic [PW-1:0] cap_m1;
    logic [PW-1:0] snap_clamped;

    assign cap_m1       = cap - 1'b1;
    assign snap_clamped = (snap_ptr > MAX_PTR) ? MAX_PTR : snap_ptr;
    assign snap_idx     = idx;
    assign rst_idx      = idx;
    assign rst_line     = snap_line;
    assign rst_ptr      = cap;
    assign idle         = (state == IDLE);

    // State, restore index and captured pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cap   <= '0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            cap   <= nxt_cap;
        end
    end

    // Next-state and strobes; a redirect always wins and restarts the walk
    always_comb begin
        nxt_state  = state;
        nxt_idx    = idx;
        nxt_cap    = cap;
        rst_we     = 1'b0;
        rst_ptr_we = 1'b0;
        done       = 1'b0;
        if (redirect) begin
            nxt_cap   = snap_clamped;
            nxt_idx   = '0;
            nxt_state = (snap_clamped == '0) ? DONE : RESTORE;
        end else begin
            unique case (state)
                IDLE: begin
                end
                RESTORE: begin
                    rst_we  = 1'b1;
                    nxt_idx = idx + 1'b1;
                    if (idx == cap_m1) begin
                        nxt_state = DONE;
                    end
                end
                DONE: begin
                    rst_ptr_we = 1'b1;
                    done       = 1'b1;
                    nxt_state  = IDLE;
                end
                default: begin
                    nxt_state = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: push/pop grant, pop result, restore.
// Optional RAS_CTRL_OVFCNT_EN adds an 8-bit saturating overflow counter.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int STACKDEEP  = STACKDEEP_DEF,
    parameter int STACKPTRW  = STACKPTRW_DEF,
    parameter int STACKWIDE  = STACKWIDE_DEF,
    parameter int RECURCOUNT = RECURCOUNT_DEF,
    localparam int LW        = STACKWIDE + RECURCOUNT
) (
    input  logic                 Clk,
    input  logic                 Rest,
    input  logic                 PUSHREQ,
    input  logic [STACKWIDE-1:0] PUSHADDR,
    output logic                 PUSHRDY,
    input  logic                 POPREQ,
    output logic                 POPRDY,
    output logic                 POPVALID,
    output logic [STACKWIDE-1:0] POPADDR,
    output logic                 POPMISS,
    input  logic                 REDIRCT,
    input  logic [STACKPTRW-1:0] SNAPPTR,
    output logic [STACKPTRW-1:0] SNAPIDX,
    input  logic [LW-1:0]        SNAPLINE,
    output logic                 STK_WABLE,
    output logic                 STK_RABLE,
    output logic [STACKWIDE-1:0] STK_DIN,
    input  logic [STACKWIDE-1:0] STK_DOUT,
    input  logic                 STK_FULL,
    input  logic                 STK_EMPTY,
    output logic                 STK_RSTWE,
    output logic [STACKPTRW-1:0] STK_RSTIDX,
    output logic [LW-1:0]        STK_RSTLINE,
    output logic                 STK_RSTPTRWE,
    output logic [STACKPTRW-1:0] STK_RSTPTR,
    output logic                 RESTOREDONE
`ifdef RAS_CTRL_OVFCNT_EN
   ,output logic [OVFCNT_W-1:0]  OVFCNT
`endif
);

    logic idle;
    logic rdy;
    logic push_grant;
    logic pop_grant;
    logic pop_vld_q;
    logic pop_miss_q;

    ras_restore_seq #(
        .DEEP (STACKDEEP),
        .PW   (STACKPTRW),
        .LW   (LW)
    ) u_seq (
        .clk        (Clk),
        .rst_n      (Rest),
        .redirect   (REDIRCT),
        .snap_ptr   (SNAPPTR),
        .snap_line  (SNAPLINE),
        .snap_idx   (SNAPIDX),
        .rst_we     (STK_RSTWE),
        .rst_idx    (STK_RSTIDX),
        .rst_line   (STK_RSTLINE),
        .rst_ptr_we (STK_RSTPTRWE),
        .rst_ptr    (STK_RSTPTR),
        .done       (RESTOREDONE),
        .idle       (idle)
    );

    // Pop has priority over push; nothing is granted during a redirect
    assign rdy        = idle & ~REDIRCT & Rest;
    assign POPRDY     = rdy;
    assign PUSHRDY    = rdy & ~POPREQ;
    assign pop_grant  = POPREQ & POPRDY;
    assign push_grant = PUSHREQ & PUSHRDY;

    assign STK_WABLE  = push_grant & ~STK_FULL;
    assign STK_DIN    = PUSHADDR;
    assign STK_RABLE  = pop_grant & ~STK_EMPTY;

    assign POPVALID   = pop_vld_q & ~REDIRCT;
    assign POPMISS    = pop_vld_q & pop_miss_q & ~REDIRCT;
    assign POPADDR    = (POPVALID & ~POPMISS) ? STK_DOUT : '0;

    // Pop result arrives the cycle after the grant
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            pop_vld_q  <= 1'b0;
            pop_miss_q <= 1'b0;
        end else begin
            pop_vld_q  <= pop_grant;
            pop_miss_q <= pop_grant & STK_EMPTY;
        end
    end

`ifdef RAS_CTRL_OVFCNT_EN
    logic [OVFCNT_W-1:0] ovf_q;

    assign OVFCNT = ovf_q;

    // Saturating count of pushes dropped because the stack was full
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            ovf_q <= '0;
        end else if (push_grant && STK_FULL && ovf_q != '1) begin
            ovf_q <= ovf_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: directed scenarios plus random traffic
// checked every cycle against a queue-based behavioural model.
module tb_ras_ctrl;

    localparam int PW = 4;
    localparam int AW = 32;
    localparam int LW = 39;

    logic          Clk = 1'b0;
    logic          Rest = 1'b0;
    logic          PUSHREQ = 1'b0;
    logic [AW-1:0] PUSHADDR = '0;
    logic          PUSHRDY;
    logic          POPREQ = 1'b0;
    logic          POPRDY;
    logic          POPVALID;
    logic [AW-1:0] POPADDR;
    logic          POPMISS;
    logic          REDIRCT = 1'b0;
    logic [PW-1:0] SNAPPTR = '0;
    logic [PW-1:0] SNAPIDX;
    logic [LW-1:0] SNAPLINE = '0;
    logic          STK_WABLE;
    logic          STK_RABLE;
    logic [AW-1:0] STK_DIN;
    logic [AW-1:0] STK_DOUT = '0;
    logic          STK_FULL = 1'b0;
    logic          STK_EMPTY = 1'b1;
    logic          STK_RSTWE;
    logic [PW-1:0] STK_RSTIDX;
    logic [LW-1:0] STK_RSTLINE;
    logic          STK_RSTPTRWE;
    logic [PW-1:0] STK_RSTPTR;
    logic          RESTOREDONE;
`ifdef RAS_CTRL_OVFCNT_EN
    logic [7:0]    OVFCNT;
`endif

    ras_ctrl dut (
        .Clk          (Clk),
        .Rest         (Rest),
        .PUSHREQ      (PUSHREQ),
        .PUSHADDR     (PUSHADDR),
        .PUSHRDY      (PUSHRDY),
        .POPREQ       (POPREQ),
        .POPRDY       (POPRDY),
        .POPVALID     (POPVALID),
        .POPADDR      (POPADDR),
        .POPMISS      (POPMISS),
        .REDIRCT      (REDIRCT),
        .SNAPPTR      (SNAPPTR),
        .SNAPIDX      (SNAPIDX),
        .SNAPLINE     (SNAPLINE),
        .STK_WABLE    (STK_WABLE),
        .STK_RABLE    (STK_RABLE),
        .STK_DIN      (STK_DIN),
        .STK_DOUT     (STK_DOUT),
        .STK_FULL     (STK_FULL),
        .STK_EMPTY    (STK_EMPTY),
        .STK_RSTWE    (STK_RSTWE),
        .STK_RSTIDX   (STK_RSTIDX),
        .STK_RSTLINE  (STK_RSTLINE),
        .STK_RSTPTRWE (STK_RSTPTRWE),
        .STK_RSTPTR   (STK_RSTPTR),
        .RESTOREDONE  (RESTOREDONE)
`ifdef RAS_CTRL_OVFCNT_EN
       ,.OVFCNT       (OVFCNT)
`endif
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: pending pop result, restore plan as a queue of
    // line indices ending in -1 (the pointer-write step), overflow count.
    bit m_pv;
    bit m_pm;
    int plan[$];
    int m_cap;
    int m_ovf;
    bit idle_m, rd, e_poprdy, e_pushrdy, popg, pushg, e_rstwe, e_done;
    int head;

    always @(negedge Clk) begin
        if (!Rest) begin
            chk("rst_wable", STK_WABLE, 0);
            chk("rst_rable", STK_RABLE, 0);
            chk("rst_rstwe", STK_RSTWE, 0);
            chk("rst_ptrwe", STK_RSTPTRWE, 0);
            chk("rst_popvalid", POPVALID, 0);
            chk("rst_done", RESTOREDONE, 0);
            plan.delete();
            m_pv  = 0;
            m_pm  = 0;
            m_cap = 0;
            m_ovf = 0;
        end else begin
            idle_m    = (plan.size() == 0);
            rd        = REDIRCT;
            e_poprdy  = idle_m && !rd;
            e_pushrdy = e_poprdy && !POPREQ;
            popg      = POPREQ && e_poprdy;
            pushg     = PUSHREQ && e_pushrdy;
            chk("poprdy", POPRDY, e_poprdy);
            chk("pushrdy", PUSHRDY, e_pushrdy);
            chk("wable", STK_WABLE, pushg && !STK_FULL);
            if (pushg && !STK_FULL) chk("din", STK_DIN, PUSHADDR);
            chk("rable", STK_RABLE, popg && !STK_EMPTY);
            chk("popvalid", POPVALID, m_pv && !rd);
            chk("popmiss", POPMISS, m_pv && m_pm && !rd);
            chk("popaddr", POPADDR,
                (m_pv && !m_pm && !rd) ? 64'(STK_DOUT) : 64'd0);
            head = idle_m ? -2 : plan[0];
            e_rstwe = !rd && head >= 0;
            e_done  = !rd && head == -1;
            chk("rstwe", STK_RSTWE, e_rstwe);
            chk("rstptrwe", STK_RSTPTRWE, e_done);
            chk("restoredone", RESTOREDONE, e_done);
            if (e_rstwe) begin
                chk("rstidx", STK_RSTIDX, head);
                chk("snapidx", SNAPIDX, head);
                chk("rstline", STK_RSTLINE, SNAPLINE);
            end
            if (e_done) chk("rstptr", STK_RSTPTR, m_cap);
`ifdef RAS_CTRL_OVFCNT_EN
            chk("ovfcnt", OVFCNT, m_ovf);
`endif
            if (rd) begin
                plan.delete();
                for (int i = 0; i < int'(SNAPPTR); i++) plan.push_back(i);
                plan.push_back(-1);
                m_cap = int'(SNAPPTR);
            end else if (!idle_m) begin
                void'(plan.pop_front());
            end
            m_pv = popg;
            m_pm = popg && STK_EMPTY;
            if (pushg && STK_FULL && m_ovf < 255) m_ovf++;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic samp();
        @(negedge Clk);
    endtask

    int cnt;
    bit seen;
    logic [63:0] rnd;

    initial begin
        samp();
        chk("reset_pushrdy", PUSHRDY, 0);
        chk("reset_popvalid", POPVALID, 0);
        repeat (2) step();
        Rest = 1'b1;

        // push then pop a hit
        PUSHREQ  = 1'b1;
        PUSHADDR = 32'h1C000100;
        samp();
        chk("d_push_wable", STK_WABLE, 1);
        chk("d_push_din", STK_DIN, 64'h1C000100);
        step();
        PUSHREQ   = 1'b0;
        POPREQ    = 1'b1;
        STK_EMPTY = 1'b0;
        samp();
        chk("d_pop_rable", STK_RABLE, 1);
        step();
        POPREQ   = 1'b0;
        STK_DOUT = 32'h1C000100;
        samp();
        chk("d_pop_valid", POPVALID, 1);
        chk("d_pop_addr", POPADDR, 64'h1C000100);
        chk("d_pop_miss", POPMISS, 0);

        // pop on empty stack
        step();
        POPREQ    = 1'b1;
        STK_EMPTY = 1'b1;
        samp();
        chk("d_miss_rable", STK_RABLE, 0);
        step();
        POPREQ = 1'b0;
        samp();
        chk("d_miss_valid", POPVALID, 1);
        chk("d_miss_miss", POPMISS, 1);
        chk("d_miss_addr", POPADDR, 0);

        // simultaneous push and pop
        step();
        PUSHREQ   = 1'b1;
        POPREQ    = 1'b1;
        STK_EMPTY = 1'b0;
        samp();
        chk("d_both_poprdy", POPRDY, 1);
        chk("d_both_pushrdy", PUSHRDY, 0);
        chk("d_both_wable", STK_WABLE, 0);
        step();
        POPREQ = 1'b0;
        samp();
        chk("d_held_pushrdy", PUSHRDY, 1);
        chk("d_held_wable", STK_WABLE, 1);

        // three pushes into a full stack
        step();
        STK_FULL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("d_full_wable", STK_WABLE, 0);
            step();
        end
        PUSHREQ  = 1'b0;
        STK_FULL = 1'b0;
        samp();
`ifdef RAS_CTRL_OVFCNT_EN
        chk("d_ovfcnt3", OVFCNT, 3);
`endif

        // restore of three lines
        step();
        REDIRCT = 1'b1;
        SNAPPTR = 4'd3;
        samp();
        chk("d_redir_pushrdy", PUSHRDY, 0);
        step();
        REDIRCT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            SNAPLINE = LW'(64'h55_0000_0000 + 64'(i));
            samp();
            chk("d_rst_we", STK_RSTWE, 1);
            chk("d_rst_idx", STK_RSTIDX, i);
            step();
        end
        samp();
        chk("d_rst_ptrwe", STK_RSTPTRWE, 1);
        chk("d_rst_ptr", STK_RSTPTR, 3);
        chk("d_rst_done", RESTOREDONE, 1);
        step();
        samp();
        chk("d_back_idle", PUSHRDY, 1);
        chk("d_done_once", RESTOREDONE, 0);

        // redirect mid-restore restarts at index 0
        step();
        REDIRCT = 1'b1;
        SNAPPTR = 4'd5;
        step();
        REDIRCT = 1'b0;
        step();
        samp();
        chk("d_abort_idx1", STK_RSTIDX, 1);
        step();
        REDIRCT = 1'b1;
        SNAPPTR = 4'd2;
        samp();
        chk("d_abort_we", STK_RSTWE, 0);
        step();
        REDIRCT = 1'b0;
        samp();
        chk("d_restart_idx0", STK_RSTIDX, 0);
        chk("d_restart_we", STK_RSTWE, 1);
        step();
        step();
        samp();
        chk("d_restart_ptr", STK_RSTPTR, 2);
        chk("d_restart_done", RESTOREDONE, 1);

        // deepest snapshot: 15 lines
        step();
        REDIRCT = 1'b1;
        SNAPPTR = 4'd15;
        step();
        REDIRCT = 1'b0;
        cnt  = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            samp();
            if (STK_RSTWE) cnt++;
            if (RESTOREDONE) seen = 1;
            step();
        end
        chk("d_deep_done_seen", seen, 1);
        chk("d_deep_lines", cnt, 15);

        // zero snapshot pointer skips straight to DONE
        REDIRCT = 1'b1;
        SNAPPTR = 4'd0;
        step();
        REDIRCT = 1'b0;
        samp();
        chk("d_zero_done", RESTOREDONE, 1);
        chk("d_zero_ptr", STK_RSTPTR, 0);
        chk("d_zero_we", STK_RSTWE, 0);
        step();

        // overflow counter saturation
        PUSHREQ  = 1'b1;
        STK_FULL = 1'b1;
        repeat (260) step();
        PUSHREQ  = 1'b0;
        STK_FULL = 1'b0;
        samp();
`ifdef RAS_CTRL_OVFCNT_EN
        chk("d_ovf_sat", OVFCNT, 255);
`endif
        step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            PUSHREQ   = 1'($urandom_range(0, 1));
            PUSHADDR  = $urandom;
            POPREQ    = ($urandom_range(0, 2) == 0);
            REDIRCT   = ($urandom_range(0, 24) == 0);
            SNAPPTR   = PW'($urandom_range(0, 15));
            rnd       = {$urandom, $urandom};
            SNAPLINE  = rnd[LW-1:0];
            STK_DOUT  = $urandom;
            STK_FULL  = ($urandom_range(0, 3) == 0);
            STK_EMPTY = ($urandom_range(0, 3) == 0);
            if (c == 1500 || c == 2200) Rest = 1'b0;
            if (c == 1502 || c == 2203) Rest = 1'b1;
            step();
        end
        REDIRCT = 1'b0;
        PUSHREQ = 1'b0;
        POPREQ  = 1'b0;
        samp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
